spi_reg_ctrl: RTL
=================

// Module: spi_reg_ctrl
// PURPOSE
//  Command sequencer behind the SPI slave byte receiver. Parses framed byte streams from the
//  SPI master (command, address, data...) into writes/reads of a small register file that
//  configures downstream logic (LED blink control etc.). Read data is handed back as bytes
//  for the SPI slave's MISO shifter. Frame boundary = CSn.
// PARAMETERS
//  NUM_REGS   8      number of 8-bit registers, 1..256
//  ADDR_W     3      width of o_wr_addr; 2**ADDR_W >= NUM_REGS
//  REG_RST    8'h00  reset value of every register
// PORTS
//  i_clk        in   1             system clock (50 MHz)
//  i_rst_n      in   1             reset, synchronous, active-low
//  i_cs_n       in   1             SPI chip select (synchronised, active-low); high = frame end
//  i_rx_valid   in   1             1-cycle pulse: i_rx_data holds a complete received byte
//  i_rx_data    in   8             received byte, MSB-first assembled
//  o_tx_data    out  8             byte for the MISO shifter to send next
//  o_tx_valid   out  1             1-cycle pulse: o_tx_data updated
//  o_wr_strobe  out  1             1-cycle pulse: register o_wr_addr was written
//  o_wr_addr    out  ADDR_W        address of the last write
//  o_regs       out  NUM_REGS*8    register file, reg n at bits [8n+7:8n]
//  o_err_cnt    out  8             protocol error count, saturates at 8'hFF
// BEHAVIOUR
//  Reset (i_rst_n low at posedge i_clk): state=IDLE, ptr=0, all regs=REG_RST, o_tx_data=0,
//   o_tx_valid=0, o_wr_strobe=0, o_wr_addr=0, o_err_cnt=0. Reset mid-frame aborts the frame;
//   rest of that frame ignored until i_cs_n goes high (state IGNORE if i_cs_n low after reset).
//  States: IDLE, ADDR_WR, ADDR_RD, WRITE, READ, IGNORE.
//  Frame byte 0 = command: 8'h01 WRITE, 8'h02 READ; anything else -> IGNORE, err++.
//  IDLE: rx_valid with i_cs_n low -> cmd decode: 01->ADDR_WR, 02->ADDR_RD, else IGNORE.
//  ADDR_*: rx_valid: byte >= NUM_REGS -> IGNORE, err++; else ptr<=byte[ADDR_W-1:0];
//   ADDR_WR->WRITE; ADDR_RD->READ and next cycle o_tx_data<=regs[byte], o_tx_valid=1.
//  WRITE: each rx_valid: regs[ptr]<=byte; next cycle o_wr_strobe=1, o_wr_addr=ptr(old);
//   ptr<=ptr+1, wraps NUM_REGS-1 -> 0 (burst auto-increment).
//  READ: each rx_valid (dummy byte, value ignored): ptr<=ptr+1 with same wrap;
//   next cycle o_tx_data<=regs[new ptr], o_tx_valid=1.
//  IGNORE: all bytes discarded, no writes, no tx.
//  Latency: rx_valid at cycle N -> register update/strobe/tx_valid registered at N+1.
//  i_cs_n high in any state -> IDLE next cycle, ptr unchanged. i_cs_n high and rx_valid in
//   same cycle: CS wins, byte discarded, no write, no err.
//  Frame ending in ADDR_* (no address byte) is not an error; frame ending anywhere else
//   silently completes.
//  rx_valid while i_cs_n high: ignored.
//  Error counter: +1 per bad command or bad address, holds at 8'hFF (no wrap).
//  o_tx_valid, o_wr_strobe never high two consecutive cycles unless rx_valid was.
//  Read in READ state uses pre-write values; same-cycle write/read impossible (one state).
// TESTING
//  1 Reset: hold i_rst_n=0 2 clks -> all regs=REG_RST, o_err_cnt=0, strobes 0, state IDLE.
//  2 Write burst: CS low, bytes 01,03,AA,BB, CS high -> reg3=AA, reg4=BB, two o_wr_strobe
//    pulses with o_wr_addr 3 then 4; other regs unchanged.
//  3 Read w/ wrap: preload reg7=5A, reg0=C3; frame 02,07,00,00 -> o_tx_valid pulses with
//    o_tx_data 5A (after addr), C3 (ptr wrapped to 0), regs[1] value.
//  4 Errors: frame 7F,.. then frame 01,08 (NUM_REGS=8) -> o_err_cnt=2, no writes;
//    300 bad frames -> o_err_cnt=FF.
//  5 Abort: frame 01,02 then CS high together with rx_valid byte 55 -> reg2 unchanged, IDLE;
//    next frame 01,02,66 -> reg2=66.
//  6 Mid-frame reset: assert i_rst_n=0 during WRITE burst, release with CS low, send 77 ->
//    ignored; after CS high/low, normal write works.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// Command sequencer behind the SPI slave byte receiver: decodes framed write/read
// commands into an 8-bit register file and returns read bytes for the MISO shifter.
module spi_reg_ctrl #(
    parameter int          NUM_REGS = 8,
    parameter int          ADDR_W   = 3,
    parameter logic [7:0]  REG_RST  = 8'h00
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cs_n,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    output logic                  o_wr_strobe,
    output logic [ADDR_W-1:0]     o_wr_addr,
    output logic [NUM_REGS*8-1:0] o_regs,
    output logic [7:0]            o_err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_WR = 3'd1,
        S_ADDR_RD = 3'd2,
        S_WRITE   = 3'd3,
        S_READ    = 3'd4,
        S_IGNORE  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [7:0]        r_regs [NUM_REGS];

    logic              w_wr_en;
    logic              w_tx_addr;
    logic              w_tx_rd;
    logic              w_err_inc;
    logic              w_ptr_ld;
    logic              w_ptr_inc;
    logic              w_addr_bad;
    logic [ADDR_W-1:0] w_addr_byte;
    logic [ADDR_W-1:0] w_ptr_next;

    assign w_addr_byte = i_rx_data[ADDR_W-1:0];
    assign w_addr_bad  = ({1'b0, i_rx_data} >= 9'(NUM_REGS));
    assign w_ptr_next  = (r_ptr == ADDR_W'(NUM_REGS - 1)) ? {ADDR_W{1'b0}} : r_ptr + ADDR_W'(1);

    // State register; a reset taken mid-frame leaves the rest of that frame ignored.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= i_cs_n ? S_IDLE : S_IGNORE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-byte action decode; chip-select release overrides any byte.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_tx_addr   = 1'b0;
        w_tx_rd     = 1'b0;
        w_err_inc   = 1'b0;
        w_ptr_ld    = 1'b0;
        w_ptr_inc   = 1'b0;
        if (i_cs_n) begin
            w_state_nxt = S_IDLE;
        end else if (i_rx_valid) begin
            case (r_state)
                S_IDLE: begin
                    case (i_rx_data)
                        8'h01:   w_state_nxt = S_ADDR_WR;
                        8'h02:   w_state_nxt = S_ADDR_RD;
                        default: begin
                            w_state_nxt = S_IGNORE;
                            w_err_inc   = 1'b1;
                        end
                    endcase
                end
                S_ADDR_WR, S_ADDR_RD: begin
                    if (w_addr_bad) begin
                        w_state_nxt = S_IGNORE;
                        w_err_inc   = 1'b1;
                    end else begin
                        w_ptr_ld    = 1'b1;
                        w_tx_addr   = (r_state == S_ADDR_RD);
                        w_state_nxt = (r_state == S_ADDR_RD) ? S_READ : S_WRITE;
                    end
                end
                S_WRITE: begin
                    w_wr_en   = 1'b1;
                    w_ptr_inc = 1'b1;
                end
                S_READ: begin
                    w_tx_rd   = 1'b1;
                    w_ptr_inc = 1'b1;
                end
                S_IGNORE: w_state_nxt = S_IGNORE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Register file, pointer, strobes, read-back byte and saturating error counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr       <= {ADDR_W{1'b0}};
            o_tx_data   <= 8'h00;
            o_tx_valid  <= 1'b0;
            o_wr_strobe <= 1'b0;
            o_wr_addr   <= {ADDR_W{1'b0}};
            o_err_cnt   <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= REG_RST;
            end
        end else begin
            o_tx_valid  <= w_tx_addr | w_tx_rd;
            o_wr_strobe <= w_wr_en;
            if (w_ptr_ld) begin
                r_ptr <= w_addr_byte;
            end else if (w_ptr_inc) begin
                r_ptr <= w_ptr_next;
            end
            if (w_wr_en) begin
                r_regs[r_ptr] <= i_rx_data;
                o_wr_addr     <= r_ptr;
            end
            // Reads sample the register that the pointer lands on, before any later write.
            if (w_tx_addr) begin
                o_tx_data <= r_regs[w_addr_byte];
            end else if (w_tx_rd) begin
                o_tx_data <= r_regs[w_ptr_next];
            end
            if (w_err_inc && (o_err_cnt != 8'hFF)) begin
                o_err_cnt <= o_err_cnt + 8'h01;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign o_regs[8*g +: 8] = r_regs[g];
    end

endmodule
